// File: rtl/lab2_drv_if.sv
// Signal bundle for lab2_drv: upstream operand handshake, evaluator issue/result
// stream and downstream result handshake. The slave view belongs to the driver
// block; the master view belongs to whatever surrounds it.
interface lab2_drv_if;
  logic        in_valid;
  logic [31:0] in_x;
  logic        in_ready;
  logic        pipe_start;
  logic [31:0] pipe_x;
  logic [31:0] pipe_y;
  logic        out_valid;
  logic [31:0] out_y;
  logic        out_ready;
  logic        busy;
  logic [15:0] done_cnt;

  modport slave (
    input  in_valid, in_x, pipe_y, out_ready,
    output in_ready, pipe_start, pipe_x, out_valid, out_y, busy, done_cnt
  );

  modport master (
    output in_valid, in_x, pipe_y, out_ready,
    input  in_ready, pipe_start, pipe_x, out_valid, out_y, busy, done_cnt
  );
endinterface

// File: rtl/lab2_drv.sv
// lab2_drv: issues operands into a fixed-latency evaluator (y = x^5 + x^2),
// tracks them with a valid shift register and collects the results into an
// output FIFO. Issue is credit-limited so that every result in flight is
// guaranteed a FIFO slot; a capture can therefore never be dropped.
// OUT_DEPTH must be a power of two between 2 and 16 so the pointers wrap
// naturally at their bit width.
module lab2_drv #(
  parameter int PIPE_LAT  = 5,
  parameter int OUT_DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  lab2_drv_if.slave bus
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int IW = $clog2(PIPE_LAT + 1);

  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic [IW-1:0]       inflight_q, inflight_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       remaining;
  logic [31:0]         out_y_q, out_y_d;
  logic [15:0]         done_q, done_d;
  logic [31:0]         mem_q [OUT_DEPTH];
  logic [31:0]         used;
  logic                issue;
  logic                capture;
  logic                pop;

  // Credits come only from registered counts; reset forces the block closed.
  assign used         = 32'(inflight_q) + 32'(count_q);
  assign bus.in_ready = ~rst & (used < 32'(OUT_DEPTH));

  assign issue          = bus.in_valid & bus.in_ready;
  assign bus.pipe_start = issue;
  assign bus.pipe_x     = issue ? bus.in_x : 32'h0;

  // The oldest tracking bit marks the edge at which pipe_y belongs to us.
  assign capture = vld_q[PIPE_LAT-1];
  assign pop     = bus.out_ready & (count_q != '0);

  assign bus.out_valid = (count_q != '0);
  assign bus.out_y     = out_y_q;
  assign bus.busy      = (inflight_q != '0) | (count_q != '0);
  assign bus.done_cnt  = done_q;

  // Next-state for tracking, counters, pointers and the registered FIFO head.
  always_comb begin
    vld_d = (vld_q << 1) | PIPE_LAT'(issue);

    inflight_d = inflight_q;
    case ({issue, capture})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase

    count_d  = count_q + CW'(capture) - CW'(pop);
    wr_ptr_d = capture ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
    done_d   = done_q + 16'(capture);

    // The head after this edge is either an entry already in storage or,
    // when the FIFO drains to nothing, the value being captured right now.
    remaining = count_q - CW'(pop);
    if (remaining == '0) begin
      out_y_d = capture ? bus.pipe_y : 32'h0;
    end else begin
      out_y_d = mem_q[rd_ptr_d];
    end
  end

  // Control state with synchronous reset discarding everything in flight or queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_y_q    <= 32'h0;
      done_q     <= 16'h0;
    end else begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_y_q    <= out_y_d;
      done_q     <= done_d;
    end
  end

  // FIFO storage needs no reset; the pointers decide what is meaningful.
  always_ff @(posedge clk) begin
    if (capture && !rst) begin
      mem_q[wr_ptr_q] <= bus.pipe_y;
    end
  end

endmodule

// File: tb/tb_lab2_drv.sv
// Self-checking bench for lab2_drv. The bench plays the evaluator (answers
// every pipe_start exactly PIPE_LAT edges later, random data otherwise) and
// keeps a queue-based reference of what has been issued, what is in flight
// and what sits in the output FIFO.
module tb_lab2_drv;
  localparam int PIPE_LAT  = 5;
  localparam int OUT_DEPTH = 8;

  typedef struct {
    int          due;
    logic [31:0] val;
  } flight_t;

  logic clk = 1'b0;
  logic rst;

  lab2_drv_if bus ();

  lab2_drv #(
    .PIPE_LAT (PIPE_LAT),
    .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  flight_t     evalQ[$];
  flight_t     mFlight[$];
  logic [31:0] mFifo[$];
  int          mDone = 0;
  int          edgeNo = 0;
  int          total = 0;
  int          bad = 0;
  bit          popNow;
  bit          issueNow;

  function automatic logic [31:0] evalRef(input logic [31:0] x);
    logic [31:0] x2;
    x2 = x * x;
    return x2 * x2 * x + x2;
  endfunction

  function automatic logic mReady();
    return !rst && ((mFlight.size() + mFifo.size()) < OUT_DEPTH);
  endfunction

  // Evaluator request capture plus reference model update at each rising edge.
  always @(posedge clk) begin
    if (bus.pipe_start === 1'b1)
      evalQ.push_back('{edgeNo + PIPE_LAT, evalRef(bus.pipe_x)});
    if (rst) begin
      mFlight.delete();
      mFifo.delete();
      mDone = 0;
    end else begin
      popNow   = bus.out_ready && (mFifo.size() > 0);
      issueNow = bus.in_valid && ((mFlight.size() + mFifo.size()) < OUT_DEPTH);
      if (popNow) void'(mFifo.pop_front());
      if (mFlight.size() > 0 && mFlight[0].due == edgeNo) begin
        mFifo.push_back(mFlight[0].val);
        void'(mFlight.pop_front());
        mDone++;
      end
      if (issueNow) mFlight.push_back('{edgeNo + PIPE_LAT, evalRef(bus.in_x)});
    end
    edgeNo++;
  end

  // Evaluator result stream, presented half a cycle before the edge it is due at.
  always @(negedge clk) begin
    if (evalQ.size() > 0 && evalQ[0].due == edgeNo) begin
      bus.pipe_y = evalQ[0].val;
      void'(evalQ.pop_front());
    end else begin
      bus.pipe_y = $urandom;
    end
  end

  task automatic drive(input logic r, input logic v, input logic [31:0] x, input logic rdy);
    @(negedge clk);
    rst           = r;
    bus.in_valid  = v;
    bus.in_x      = x;
    bus.out_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, $urandom, 1'b1);
      total += 6;
      if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=0", bus.in_ready); end
      if (bus.pipe_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_pipe_start got=%b want=0", bus.pipe_start); end
      if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
      if (bus.done_cnt !== 16'h0) begin bad++; $display("[TB] FAIL reset_done_cnt got=%h want=0", bus.done_cnt); end
      if (bus.out_y !== 32'h0) begin bad++; $display("[TB] FAIL reset_out_y got=%h want=0", bus.out_y); end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_in_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_single();
    drive(1'b0, 1'b1, 32'd2, 1'b1);
    total += 2;
    if (bus.pipe_start !== 1'b1) begin bad++; $display("[TB] FAIL single_issue got=%b want=1", bus.pipe_start); end
    if (bus.pipe_x !== 32'd2) begin bad++; $display("[TB] FAIL single_pipe_x got=%h want=2", bus.pipe_x); end
    for (int k = 1; k <= PIPE_LAT + 3; k++) begin
      drive(1'b0, 1'b0, $urandom, 1'b1);
      total += 4;
      if (bus.pipe_start !== 1'b0) begin bad++; $display("[TB] FAIL single_no_reissue k=%0d got=%b want=0", k, bus.pipe_start); end
      if (bus.out_valid !== (k == PIPE_LAT + 1)) begin bad++; $display("[TB] FAIL single_out_valid k=%0d got=%b want=%b", k, bus.out_valid, (k == PIPE_LAT + 1)); end
      if (bus.done_cnt !== ((k >= PIPE_LAT + 1) ? 16'd1 : 16'd0)) begin bad++; $display("[TB] FAIL single_done_cnt k=%0d got=%0d", k, bus.done_cnt); end
      if (bus.busy !== (k <= PIPE_LAT + 1)) begin bad++; $display("[TB] FAIL single_busy k=%0d got=%b want=%b", k, bus.busy, (k <= PIPE_LAT + 1)); end
      if (k == PIPE_LAT + 1) begin
        total++;
        if (bus.out_y !== 32'h24) begin bad++; $display("[TB] FAIL single_out_y got=%h want=00000024", bus.out_y); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs [5];
    logic [31:0] want [5];
    int got;
    xs   = '{32'h0, 32'h1, 32'h3, 32'h100, 32'h10000};
    want = '{32'h0, 32'h2, 32'd252, 32'h00010000, 32'h0};
    got  = 0;
    for (int j = 0; j < 5 + PIPE_LAT + 4; j++) begin
      if (j < 5) drive(1'b0, 1'b1, xs[j], 1'b1);
      else       drive(1'b0, 1'b0, $urandom, 1'b1);
      if (bus.out_valid === 1'b1) begin
        total++;
        if (got >= 5) begin
          bad++; $display("[TB] FAIL b2b_extra j=%0d got=%h want=none", j, bus.out_y);
        end else if (bus.out_y !== want[got] || j != PIPE_LAT + 1 + got) begin
          bad++; $display("[TB] FAIL b2b_result idx=%0d step=%0d got=%h want=%h at step %0d", got, j, bus.out_y, want[got], PIPE_LAT + 1 + got);
        end
        got++;
      end
    end
    total++;
    if (got != 5) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=5", got); end
  endtask

  task automatic test_fill_drain();
    int issued;
    issued = 0;
    for (int j = 0; j < OUT_DEPTH + PIPE_LAT + 3; j++) begin
      drive(1'b0, 1'b1, $urandom, 1'b0);
      if (bus.pipe_start === 1'b1) issued++;
      total++;
      if (bus.in_ready !== mReady()) begin bad++; $display("[TB] FAIL fill_in_ready j=%0d got=%b want=%b", j, bus.in_ready, mReady()); end
    end
    total += 4;
    if (issued != OUT_DEPTH) begin bad++; $display("[TB] FAIL fill_issue_count got=%0d want=%0d", issued, OUT_DEPTH); end
    if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_full_in_ready got=%b want=0", bus.in_ready); end
    if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL fill_out_valid got=%b want=1", bus.out_valid); end
    if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL fill_busy got=%b want=1", bus.busy); end
    for (int j = 0; j < 3 * OUT_DEPTH + PIPE_LAT + 3; j++) begin
      drive(1'b0, (j < 3 * OUT_DEPTH), $urandom, 1'b1);
      total += 2;
      if (bus.pipe_start !== (bus.in_valid & mReady())) begin bad++; $display("[TB] FAIL drain_issue j=%0d got=%b want=%b", j, bus.pipe_start, bus.in_valid & mReady()); end
      if (bus.out_valid !== (mFifo.size() != 0)) begin bad++; $display("[TB] FAIL drain_out_valid j=%0d got=%b want=%b", j, bus.out_valid, mFifo.size() != 0); end
      if (mFifo.size() != 0) begin
        total++;
        if (bus.out_y !== mFifo[0]) begin bad++; $display("[TB] FAIL drain_out_y j=%0d got=%h want=%h", j, bus.out_y, mFifo[0]); end
      end
    end
    total += 2;
    if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_empty got=%b want=0", bus.out_valid); end
    if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL drain_idle_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_random_traffic(input int pv, input int pr, input int cycles);
    logic expIssue;
    for (int j = 0; j < cycles; j++) begin
      drive(1'b0, ($urandom_range(0, 99) < pv), $urandom, ($urandom_range(0, 99) < pr));
      expIssue = bus.in_valid & mReady();
      total += 6;
      if (bus.in_ready !== mReady()) begin bad++; $display("[TB] FAIL rand_in_ready j=%0d got=%b want=%b", j, bus.in_ready, mReady()); end
      if (bus.pipe_start !== expIssue) begin bad++; $display("[TB] FAIL rand_pipe_start j=%0d got=%b want=%b", j, bus.pipe_start, expIssue); end
      if (bus.pipe_x !== (expIssue ? bus.in_x : 32'h0)) begin bad++; $display("[TB] FAIL rand_pipe_x j=%0d got=%h want=%h", j, bus.pipe_x, expIssue ? bus.in_x : 32'h0); end
      if (bus.out_valid !== (mFifo.size() != 0)) begin bad++; $display("[TB] FAIL rand_out_valid j=%0d got=%b want=%b", j, bus.out_valid, mFifo.size() != 0); end
      if (bus.busy !== ((mFlight.size() + mFifo.size()) != 0)) begin bad++; $display("[TB] FAIL rand_busy j=%0d got=%b", j, bus.busy); end
      if (bus.done_cnt !== 16'(mDone)) begin bad++; $display("[TB] FAIL rand_done_cnt j=%0d got=%h want=%h", j, bus.done_cnt, 16'(mDone)); end
      if (mFifo.size() != 0) begin
        total++;
        if (bus.out_y !== mFifo[0]) begin bad++; $display("[TB] FAIL rand_out_y j=%0d got=%h want=%h", j, bus.out_y, mFifo[0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, $urandom, 1'b0);
    drive(1'b0, 1'b1, $urandom, 1'b0);
    for (int j = 0; j < PIPE_LAT; j++) drive(1'b0, 1'b0, $urandom, 1'b0);
    for (int j = 0; j < 3; j++) drive(1'b0, 1'b1, $urandom, 1'b0);
    drive(1'b1, 1'b1, $urandom, 1'b0);
    total += 3;
    if (bus.done_cnt !== 16'd2) begin bad++; $display("[TB] FAIL mid_pre_done got=%0d want=2", bus.done_cnt); end
    if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_valid got=%b want=1", bus.out_valid); end
    if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_in_ready got=%b want=0", bus.in_ready); end
    for (int j = 0; j < PIPE_LAT + 2; j++) begin
      drive(1'b0, 1'b0, $urandom, 1'b1);
      total += 3;
      if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_out_valid j=%0d got=%b want=0", j, bus.out_valid); end
      if (bus.done_cnt !== 16'd0) begin bad++; $display("[TB] FAIL mid_done_cnt j=%0d got=%0d want=0", j, bus.done_cnt); end
      if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy j=%0d got=%b want=0", j, bus.busy); end
    end
  endtask

  task automatic test_done_wrap();
    bit sawWrap;
    bit finished;
    sawWrap  = 0;
    finished = 0;
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 70000 && !finished; c++) begin
      drive(1'b0, 1'b1, $urandom, 1'b1);
      total++;
      if (bus.done_cnt !== 16'(mDone)) begin bad++; $display("[TB] FAIL wrap_done_cnt c=%0d got=%h want=%h", c, bus.done_cnt, 16'(mDone)); end
      if (mFifo.size() != 0) begin
        total++;
        if (bus.out_y !== mFifo[0]) begin bad++; $display("[TB] FAIL wrap_out_y c=%0d got=%h want=%h", c, bus.out_y, mFifo[0]); end
      end
      if (mDone == 65536 && !sawWrap) begin
        sawWrap = 1;
        total++;
        if (bus.done_cnt !== 16'h0000) begin bad++; $display("[TB] FAIL wrap_zero got=%h want=0000", bus.done_cnt); end
      end
      if (mDone >= 65537) finished = 1;
    end
    total++;
    if (!finished || !sawWrap) begin bad++; $display("[TB] FAIL wrap_timeout captures=%0d want>=65537", mDone); end
  endtask

  // Scenario sequence, then the single summary line.
  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = 32'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_drain();
    test_random_traffic(90, 50, 200);
    test_random_traffic(100, 30, 200);
    test_random_traffic(40, 90, 150);
    test_reset_mid();
    test_random_traffic(70, 70, 100);
    test_done_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
